// File: rtl/hsiao_ecc_scrubber_if.sv
// Arbiter-side memory port of the Hsiao (13,8) scrubber.
// Request/grant handshake; read data returns the cycle after a granted read.
interface hsiao_ecc_scrubber_if #(
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [12:0]       mem_wdata;
   logic              mem_gnt;
   logic [12:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rdata
   );
endinterface

// File: rtl/hsiao_ecc_scrubber.sv
// Background scrubber for Hsiao (13,8) SEC-DED memory: reads every word once per pass,
// writes back single-bit corrections, and keeps saturating SEC/DED statistics.
module hsiao_ecc_scrubber #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 clear_stats,
   output logic                 busy,
   output logic                 done,
   hsiao_ecc_scrubber_if.master mem,
   output logic [CNT_W-1:0]     sec_count,
   output logic [CNT_W-1:0]     ded_count,
   output logic                 ded_flag,
   output logic [ADDR_W-1:0]    ded_addr
);
   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CHECK, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr;
   logic [12:0]       word;
   logic [4:0]        syndrome;
   logic [12:0]       flip;
   logic              is_sec;
   logic              is_ded;
   logic              advance;
   logic              last;

   always_comb begin
      syndrome[4] = word[12] ^ word[11] ^ word[10] ^ word[9] ^ word[4];
      syndrome[3] = word[12] ^ word[8] ^ word[7] ^ word[6] ^ word[3];
      syndrome[2] = word[11] ^ word[10] ^ word[7] ^ word[6] ^ word[5] ^ word[2];
      syndrome[1] = word[11] ^ word[9] ^ word[8] ^ word[6] ^ word[5] ^ word[1];
      syndrome[0] = word[12] ^ word[10] ^ word[9] ^ word[8] ^ word[7] ^ word[5] ^ word[0];
   end

   // A syndrome matching an H-matrix column names the single bit to flip; anything else nonzero is DED.
   always_comb begin
      flip = '0;
      case (syndrome)
         5'd25:   flip[12] = 1'b1;
         5'd22:   flip[11] = 1'b1;
         5'd21:   flip[10] = 1'b1;
         5'd19:   flip[9]  = 1'b1;
         5'd11:   flip[8]  = 1'b1;
         5'd13:   flip[7]  = 1'b1;
         5'd14:   flip[6]  = 1'b1;
         5'd7:    flip[5]  = 1'b1;
         5'd16:   flip[4]  = 1'b1;
         5'd8:    flip[3]  = 1'b1;
         5'd4:    flip[2]  = 1'b1;
         5'd2:    flip[1]  = 1'b1;
         5'd1:    flip[0]  = 1'b1;
         default: flip     = '0;
      endcase
   end

   assign is_sec = |flip;
   assign is_ded = (syndrome != 5'd0) && !is_sec;
   assign last   = (addr == LAST_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      advance    = 1'b0;
      case (state)
         S_IDLE:  if (start) state_next = S_READ;
         S_READ:  if (mem.mem_gnt) state_next = S_WAIT;
         S_WAIT:  state_next = S_CHECK;
         S_CHECK: if (is_sec) state_next = S_WRITE;
                  else        advance    = 1'b1;
         S_WRITE: if (mem.mem_gnt) advance = 1'b1;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (advance) state_next = last ? S_DONE : S_READ;
   end

   // The word register holds the raw read, then the corrected codeword that WRITE drives out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
         word <= '0;
      end else begin
         if (state == S_IDLE && start) addr <= '0;
         else if (advance && !last)    addr <= addr + ADDR_W'(1);
         if (state == S_WAIT)          word <= mem.mem_rdata;
         else if (state == S_CHECK)    word <= word ^ flip;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_count <= '0;
         ded_count <= '0;
         ded_flag  <= 1'b0;
         ded_addr  <= '0;
      end else if (clear_stats) begin
         sec_count <= '0;
         ded_count <= '0;
         ded_flag  <= 1'b0;
         ded_addr  <= '0;
      end else if (state == S_CHECK) begin
         if (is_sec && sec_count != '1) sec_count <= sec_count + CNT_W'(1);
         if (is_ded) begin
            if (ded_count != '1) ded_count <= ded_count + CNT_W'(1);
            if (!ded_flag) begin
               ded_flag <= 1'b1;
               ded_addr <= addr;
            end
         end
      end
   end

   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign mem.mem_req   = (state == S_READ) || (state == S_WRITE);
   assign mem.mem_we    = (state == S_WRITE);
   assign mem.mem_addr  = addr;
   assign mem.mem_wdata = (state == S_WRITE) ? word : 13'd0;
endmodule

// File: tb/tb_hsiao_ecc_scrubber.sv
// Directed bench for hsiao_ecc_scrubber: behavioural memory with programmable grant stalls,
// table-driven error pass plus hand-written reset/stall/saturation/clear sequences.
module tb_hsiao_ecc_scrubber;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              clear_stats;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  sec_count;
   logic [CNT_W-1:0]  ded_count;
   logic              ded_flag;
   logic [ADDR_W-1:0] ded_addr;

   int checks = 0;
   int fails  = 0;

   hsiao_ecc_scrubber_if #(.ADDR_W(ADDR_W)) mem_if ();

   hsiao_ecc_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .clear_stats (clear_stats),
      .busy        (busy),
      .done        (done),
      .mem         (mem_if.master),
      .sec_count   (sec_count),
      .ded_count   (ded_count),
      .ded_flag    (ded_flag),
      .ded_addr    (ded_addr)
   );

   always #5 clk = ~clk;

   logic [12:0] mem [0:DEPTH-1];
   logic [7:0]  rd_stall_addr;
   logic [7:0]  wr_stall_addr;
   int          rd_stall_n;
   int          wr_stall_n;
   int          rd_cnt   = 0;
   int          wr_cnt   = 0;
   int          wr_count = 0;
   logic [7:0]  wr_addr_log [0:15];
   logic [12:0] wr_data_log [0:15];

   assign mem_if.mem_gnt = mem_if.mem_req &&
      !((!mem_if.mem_we && mem_if.mem_addr == rd_stall_addr && rd_cnt < rd_stall_n) ||
        ( mem_if.mem_we && mem_if.mem_addr == wr_stall_addr && wr_cnt < wr_stall_n));

   // Memory model: stall/write bookkeeping restarts whenever a pass is started.
   always @(posedge clk) begin
      if (start) begin
         rd_cnt   <= 0;
         wr_cnt   <= 0;
         wr_count <= 0;
      end else begin
         if (mem_if.mem_req && !mem_if.mem_gnt) begin
            if (mem_if.mem_we) wr_cnt <= wr_cnt + 1;
            else               rd_cnt <= rd_cnt + 1;
         end
         if (mem_if.mem_req && mem_if.mem_gnt && mem_if.mem_we) begin
            if (wr_count < 16) begin
               wr_addr_log[wr_count[3:0]] <= mem_if.mem_addr;
               wr_data_log[wr_count[3:0]] <= mem_if.mem_wdata;
            end
            wr_count <= wr_count + 1;
         end
      end
      if (mem_if.mem_req && mem_if.mem_gnt && !mem_if.mem_we) mem_if.mem_rdata <= mem[mem_if.mem_addr];
   end

   function automatic logic [12:0] encode(input logic [7:0] d);
      logic [12:0] c;
      c    = {d, 5'b0};
      c[4] = c[12] ^ c[11] ^ c[10] ^ c[9];
      c[3] = c[12] ^ c[8] ^ c[7] ^ c[6];
      c[2] = c[11] ^ c[10] ^ c[7] ^ c[6] ^ c[5];
      c[1] = c[11] ^ c[9] ^ c[8] ^ c[6] ^ c[5];
      c[0] = c[12] ^ c[10] ^ c[9] ^ c[8] ^ c[7] ^ c[5];
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic loadClean();
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] d;
         d      = i[7:0];
         mem[i] = encode(d);
      end
   endtask

   task automatic pulseClear();
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
   endtask

   // Runs one full pass from cycle 0, checking length, stall count and held request fields.
   task automatic applyStimulus(input string tag, input int expCycles, input int expStalls);
      int          cycles;
      int          stalls;
      logic        prevStall;
      logic        pWe;
      logic [7:0]  pAddr;
      logic [12:0] pWdata;
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles    = 1;
      stalls    = 0;
      prevStall = 1'b0;
      pWe       = 1'b0;
      pAddr     = '0;
      pWdata    = '0;
      checkOutput({tag, " first req"}, 32'(mem_if.mem_req), 32'd1);
      checkOutput({tag, " first addr"}, 32'(mem_if.mem_addr), 32'd0);
      while (cycles < 4000) begin
         if (prevStall) begin
            checkOutput({tag, " stall req held"}, 32'(mem_if.mem_req), 32'd1);
            checkOutput({tag, " stall we held"}, 32'(mem_if.mem_we), 32'(pWe));
            checkOutput({tag, " stall addr held"}, 32'(mem_if.mem_addr), 32'(pAddr));
            checkOutput({tag, " stall wdata held"}, 32'(mem_if.mem_wdata), 32'(pWdata));
         end
         if (done) break;
         prevStall = mem_if.mem_req && !mem_if.mem_gnt;
         if (prevStall) stalls++;
         pWe    = mem_if.mem_we;
         pAddr  = mem_if.mem_addr;
         pWdata = mem_if.mem_wdata;
         tick();
         cycles++;
      end
      checkOutput({tag, " pass length"}, 32'(cycles), 32'(expCycles));
      checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(expStalls));
      checkOutput({tag, " busy during done"}, 32'(busy), 32'd1);
      tick();
      checkOutput({tag, " idle after done"}, 32'({busy, done, mem_if.mem_req}), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic [12:0] stored;
      int          kind;
      logic [12:0] fixed;
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs [NVEC];

   initial begin
      int j;
      int expSec;
      int expDed;
      int k;

      // kind: 0 clean, 1 SEC (fixed = expected write-back), 2 DED
      vecs[0] = '{8'h10, 13'h1486, 1, 13'h14A6};
      vecs[1] = '{8'h20, 13'h1001, 2, 13'h0000};
      vecs[2] = '{8'h30, 13'h0006, 2, 13'h0000};
      vecs[3] = '{8'h40, 13'h001C, 2, 13'h0000};
      vecs[4] = '{8'h50, 13'h1FEE, 1, 13'h1FE6};
      vecs[5] = '{8'h60, 13'h14A6, 0, 13'h14A6};

      rst           = 1'b1;
      start         = 1'b0;
      clear_stats   = 1'b0;
      rd_stall_addr = '0;
      wr_stall_addr = '0;
      rd_stall_n    = 0;
      wr_stall_n    = 0;
      loadClean();
      tick();
      tick();
      tick();
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset mem_req", 32'(mem_if.mem_req), 32'd0);
      checkOutput("reset mem_we", 32'(mem_if.mem_we), 32'd0);
      checkOutput("reset mem_addr", 32'(mem_if.mem_addr), 32'd0);
      checkOutput("reset mem_wdata", 32'(mem_if.mem_wdata), 32'd0);
      checkOutput("reset sec_count", 32'(sec_count), 32'd0);
      checkOutput("reset ded_count", 32'(ded_count), 32'd0);
      checkOutput("reset ded_flag", 32'(ded_flag), 32'd0);
      checkOutput("reset ded_addr", 32'(ded_addr), 32'd0);

      $display("[TB] clean pass");
      applyStimulus("clean", 769, 0);
      checkOutput("clean writes", 32'(wr_count), 32'd0);
      checkOutput("clean sec_count", 32'(sec_count), 32'd0);
      checkOutput("clean ded_count", 32'(ded_count), 32'd0);
      checkOutput("clean ded_flag", 32'(ded_flag), 32'd0);

      $display("[TB] table-driven error pass");
      loadClean();
      for (int i = 0; i < NVEC; i++) mem[vecs[i].addr] = vecs[i].stored;
      j      = 0;
      expSec = 0;
      expDed = 0;
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].kind == 1)      expSec++;
         else if (vecs[i].kind == 2) expDed++;
      end
      applyStimulus("table", 3 * DEPTH + 1 + expSec, 0);
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].kind == 1) begin
            checkOutput("table write addr", 32'(wr_addr_log[j[3:0]]), 32'(vecs[i].addr));
            checkOutput("table write data", 32'(wr_data_log[j[3:0]]), 32'(vecs[i].fixed));
            j++;
         end
      end
      checkOutput("table write count", 32'(wr_count), 32'(j));
      checkOutput("table sec_count", 32'(sec_count), 32'((expSec > 3) ? 3 : expSec));
      checkOutput("table ded_count", 32'(ded_count), 32'((expDed > 3) ? 3 : expDed));
      checkOutput("table ded_flag", 32'(ded_flag), 32'd1);
      checkOutput("table ded_addr", 32'(ded_addr), 32'h20);

      $display("[TB] clear_stats");
      pulseClear();
      checkOutput("clear sec_count", 32'(sec_count), 32'd0);
      checkOutput("clear ded_count", 32'(ded_count), 32'd0);
      checkOutput("clear ded_flag", 32'(ded_flag), 32'd0);
      checkOutput("clear ded_addr", 32'(ded_addr), 32'd0);

      $display("[TB] grant stalls: 3 on read of 0x03, 2 on write of 0x05");
      loadClean();
      mem[5]        = encode(8'h05) ^ 13'h0100;
      rd_stall_addr = 8'h03;
      rd_stall_n    = 3;
      wr_stall_addr = 8'h05;
      wr_stall_n    = 2;
      applyStimulus("stall", 3 * DEPTH + 1 + 1 + 5, 5);
      rd_stall_n = 0;
      wr_stall_n = 0;
      checkOutput("stall write count", 32'(wr_count), 32'd1);
      checkOutput("stall write addr", 32'(wr_addr_log[0]), 32'h05);
      checkOutput("stall write data", 32'(wr_data_log[0]), 32'(encode(8'h05)));
      checkOutput("stall sec_count", 32'(sec_count), 32'd1);

      $display("[TB] saturation with five SEC words");
      pulseClear();
      loadClean();
      for (int i = 0; i < 5; i++) mem[i] = mem[i] ^ (13'd1 << i);
      applyStimulus("sat", 3 * DEPTH + 1 + 5, 0);
      checkOutput("sat write count", 32'(wr_count), 32'd5);
      checkOutput("sat last write data", 32'(wr_data_log[4]), 32'(encode(8'h04)));
      checkOutput("sat sec_count", 32'(sec_count), 32'd3);
      checkOutput("sat ded_count", 32'(ded_count), 32'd0);

      $display("[TB] clear_stats during CHECK of a SEC word");
      loadClean();
      mem[8'h80] = encode(8'h80) ^ 13'h0200;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (k < 1000 && !(mem_if.mem_req && !mem_if.mem_we && mem_if.mem_addr == 8'h80)) begin
         tick();
         k++;
      end
      checkOutput("reach read 0x80", 32'(mem_if.mem_req && mem_if.mem_addr == 8'h80), 32'd1);
      tick();
      tick();
      checkOutput("sec_count before clear", 32'(sec_count), 32'd3);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      checkOutput("clear beats increment", 32'(sec_count), 32'd0);
      checkOutput("write follows check", 32'(mem_if.mem_req && mem_if.mem_we), 32'd1);
      k = 0;
      while (k < 2000 && !done) begin
         tick();
         k++;
      end
      checkOutput("clear pass done", 32'(done), 32'd1);
      tick();
      checkOutput("clear pass sec_count", 32'(sec_count), 32'd0);
      checkOutput("clear pass writes", 32'(wr_count), 32'd1);

      $display("[TB] reset during a stalled WRITE");
      loadClean();
      mem[2]        = encode(8'h02) ^ 13'h0080;
      wr_stall_addr = 8'h02;
      wr_stall_n    = 100;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (k < 100 && !(mem_if.mem_req && mem_if.mem_we)) begin
         tick();
         k++;
      end
      checkOutput("reach write", 32'(mem_if.mem_req && mem_if.mem_we), 32'd1);
      checkOutput("sec before reset", 32'(sec_count), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async req drop", 32'(mem_if.mem_req), 32'd0);
      checkOutput("async we drop", 32'(mem_if.mem_we), 32'd0);
      checkOutput("async busy drop", 32'(busy), 32'd0);
      checkOutput("async wdata zero", 32'(mem_if.mem_wdata), 32'd0);
      checkOutput("async addr zero", 32'(mem_if.mem_addr), 32'd0);
      checkOutput("async sec cleared", 32'(sec_count), 32'd0);
      tick();
      tick();
      rst        = 1'b0;
      wr_stall_n = 0;
      checkOutput("no partial write", 32'(wr_count), 32'd0);
      applyStimulus("restart", 3 * DEPTH + 1 + 1, 0);
      checkOutput("restart write count", 32'(wr_count), 32'd1);
      checkOutput("restart write addr", 32'(wr_addr_log[0]), 32'h02);
      checkOutput("restart write data", 32'(wr_data_log[0]), 32'(encode(8'h02)));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
